mips_fetch_stage: RTL and testbench

//  Instruction fetch stage directly upstream of the control/decode unit. Holds the PC,

---
 rtl/mips_pkg.sv | 36 +++
 rtl/fetch_skid_reg.sv | 51 +++++
 rtl/mips_fetch_stage.sv | 170 +++++++++++++++++
 tb/tb_mips_fetch_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared widths, fetch-state encoding and opcode constants for
//                the MIPS instruction fetch stage and its benches.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int OPC_W   = 6;
    localparam int FUNCT_W = 6;
    localparam int INSTR_W = 32;

    // Fetch state machine encoding
    localparam int                 STATE_W  = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [STATE_W-1:0] ST_WAIT  = 2'd2;
    localparam logic [STATE_W-1:0] ST_FULL  = 2'd3;

    // Opcode values of interest to control and to benches
    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;

    function automatic logic [OPC_W-1:0] instr_opc(input logic [INSTR_W-1:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [FUNCT_W-1:0] instr_funct(input logic [INSTR_W-1:0] instr);
        return instr[5:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_reg
//  Description : One-entry holding register for an instruction word and its
//                pc+4 that returned from memory while decode was stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_unload,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc_plus4,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc_plus4,
    output logic               o_full
);

    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc_plus4;
    logic               r_full;

    // Capture on load, empty on unload; a clear (redirect) wins over both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_full     <= 1'b0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_full     <= 1'b1;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_full     = r_full;

endmodule
`default_nettype wire

// File: rtl/mips_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mips_fetch_stage
//  Description : Instruction fetch stage. Holds the PC, issues one memory read
//                at a time, presents the fetched word and its opcode/funct
//                fields to decode, honours stall and branch redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [OPC_W-1:0]   if_opc,
    output logic [FUNCT_W-1:0] if_funct,
    output logic [ADDR_W-1:0]  if_pc_plus4
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic               r_kill;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_if_valid;
    logic [INSTR_W-1:0] r_if_instr;
    logic [ADDR_W-1:0]  r_if_pc_plus4;

    logic [ADDR_W-1:0]  w_pc_plus4;
    logic [ADDR_W-1:0]  w_target;
    logic               w_slot_free;
    logic               w_redirect;
    logic               w_rsp;
    logic               w_skid_load;
    logic               w_skid_unload;
    logic               w_skid_clear;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [ADDR_W-1:0]  w_skid_pc_plus4;
    logic               w_skid_full;

    // PC increment wraps naturally at the top of the address space
    assign w_pc_plus4  = r_pc + ADDR_W'(4);
    // Branch targets are always word aligned
    assign w_target    = branch_target & ~ADDR_W'(3);
    // Decode takes the current word this cycle, or there is none to take
    assign w_slot_free = !r_if_valid || !stall;
    // IDLE only latches a new PC; every other state also flushes
    assign w_redirect  = branch_taken && (r_state != ST_IDLE);
    // A response only counts while a read is actually outstanding
    assign w_rsp       = (r_state == ST_WAIT) && imem_valid;

    assign w_skid_load   = w_rsp && !r_kill && !w_slot_free && !branch_taken;
    assign w_skid_unload = (r_state == ST_FULL) && w_skid_full && !stall && !branch_taken;
    assign w_skid_clear  = w_redirect;

    fetch_skid_reg #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_skid_load),
        .i_unload   (w_skid_unload),
        .i_clear    (w_skid_clear),
        .i_instr    (imem_rdata),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (w_skid_instr),
        .o_pc_plus4 (w_skid_pc_plus4),
        .o_full     (w_skid_full)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; redirect takes priority over response and stall
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (branch_taken) begin
                    w_next_state = imem_valid ? ST_ISSUE : ST_WAIT;
                end else if (imem_valid) begin
                    w_next_state = (r_kill || w_slot_free) ? ST_ISSUE : ST_FULL;
                end
            end
            ST_FULL: begin
                if (branch_taken || !stall) begin
                    w_next_state = ST_ISSUE;
                end
            end
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Memory request outputs, address forced to zero when not requesting
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = '0;
        if (r_state == ST_ISSUE) begin
            imem_req  = 1'b1;
            imem_addr = r_pc;
        end
    end

    // PC, kill flag and decode-facing output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_kill        <= 1'b0;
            r_if_valid    <= 1'b0;
            r_if_instr    <= '0;
            r_if_pc_plus4 <= '0;
        end else begin
            // A word shown while stall is low has been consumed
            if (!stall) begin
                r_if_valid <= 1'b0;
            end

            if (w_redirect) begin
                r_pc       <= w_target;
                r_if_valid <= 1'b0;
                // Only a read still in flight needs its data discarded later
                r_kill     <= (r_state == ST_ISSUE) ||
                              ((r_state == ST_WAIT) && !imem_valid);
            end else if (branch_taken) begin
                r_pc <= w_target;
            end else if (w_rsp) begin
                if (r_kill) begin
                    r_kill <= 1'b0;
                end else begin
                    r_pc <= w_pc_plus4;
                    if (w_slot_free) begin
                        r_if_valid    <= 1'b1;
                        r_if_instr    <= imem_rdata;
                        r_if_pc_plus4 <= w_pc_plus4;
                    end
                end
            end else if (w_skid_unload) begin
                r_if_valid    <= 1'b1;
                r_if_instr    <= w_skid_instr;
                r_if_pc_plus4 <= w_skid_pc_plus4;
            end
        end
    end

    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_opc      = instr_opc(r_if_instr);
    assign if_funct    = instr_funct(r_if_instr);
    assign if_pc_plus4 = r_if_pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_fetch_stage
//  Description : Self-checking bench for mips_fetch_stage: memory responder,
//                instruction scoreboard, cycle vector table and hand-written
//                redirect / wrap / reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_fetch_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Primary DUT (RESET_PC = 0)
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [5:0]  if_opc;
    logic [5:0]  if_funct;
    logic [31:0] if_pc_plus4;

    // Second DUT at the top of the address space
    logic        rst2_n;
    logic        req2;
    logic [31:0] addr2;
    logic        valid2;
    logic [31:0] rdata2;
    logic        if_valid2;
    logic [31:0] if_instr2;
    logic [5:0]  if_opc2;
    logic [5:0]  if_funct2;
    logic [31:0] if_pc_plus4_2;

    mips_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_opc        (if_opc),
        .if_funct      (if_funct),
        .if_pc_plus4   (if_pc_plus4)
    );

    mips_fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk           (clk),
        .rst_n         (rst2_n),
        .imem_req      (req2),
        .imem_addr     (addr2),
        .imem_valid    (valid2),
        .imem_rdata    (rdata2),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (32'h0),
        .if_valid      (if_valid2),
        .if_instr      (if_instr2),
        .if_opc        (if_opc2),
        .if_funct      (if_funct2),
        .if_pc_plus4   (if_pc_plus4_2)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard of words decode should see, in order
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;
    exp_t sb[$];

    // Memory responder state
    bit          mem_busy = 1'b0;
    bit          mem_kill = 1'b0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;
    logic [31:0] mem_addr = '0;

    // Instruction memory contents: opcode chosen by address bits [3:2]
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [5:0] opc;
        case (a[3:2])
            2'd0:    opc = OPC_RTYPE;
            2'd1:    opc = OPC_LW;
            2'd2:    opc = OPC_SW;
            default: opc = OPC_BEQ;
        endcase
        return {opc, a[21:2] ^ 20'h5A5A5, a[7:2] + 6'd17};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: settle consumption at the edge, then run the memory model
    task automatic tick();
        exp_t e;
        if (branch_taken) begin
            sb.delete();
            if (mem_busy) mem_kill = 1'b1;
        end else if (if_valid && !stall) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h expected none", if_instr);
            end else begin
                e = sb.pop_front();
                check32("sb_instr", if_instr, e.instr);
                check32("sb_opc", 32'(if_opc), 32'(e.instr[31:26]));
                check32("sb_funct", 32'(if_funct), 32'(e.instr[5:0]));
                check32("sb_pc4", if_pc_plus4, e.pc4);
            end
        end
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        imem_rdata = '0;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_busy   = 1'b0;
                imem_valid = 1'b1;
                imem_rdata = mem_word(mem_addr);
                if (!mem_kill) begin
                    e.instr = mem_word(mem_addr);
                    e.pc4   = mem_addr + 32'd4;
                    sb.push_back(e);
                end
                mem_kill = 1'b0;
            end
        end
        if (imem_req) begin
            mem_busy = 1'b1;
            mem_kill = 1'b0;
            mem_cnt  = mem_lat;
            mem_addr = imem_addr;
        end
    endtask

    // Bounded wait for the next request, then compare its address
    task automatic wait_req(input string name, input logic [31:0] exp_addr);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        check32(name, imem_req ? imem_addr : 32'hDEAD_BEEF, exp_addr);
    endtask

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [5:0]  exp_opc;
        logic [31:0] exp_instr;
        logic        exp_full;
    } vec_t;
    vec_t vecs [13];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;

        // Straight-line fetch, then a 3-cycle stall that fills the skid
        vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, OPC_RTYPE, 32'h0,              1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h00, 1'b0, OPC_RTYPE, 32'h0,              1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h04, 1'b1, OPC_RTYPE, mem_word(32'h00),   1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b0, OPC_RTYPE, 32'h0,              1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h08, 1'b1, OPC_LW,    mem_word(32'h04),   1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b0, OPC_RTYPE, 32'h0,              1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0C, 1'b1, OPC_SW,    mem_word(32'h08),   1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b0, OPC_RTYPE, 32'h0,              1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h10, 1'b1, OPC_BEQ,   mem_word(32'h0C),   1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, OPC_BEQ,   mem_word(32'h0C),   1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h00, 1'b1, OPC_BEQ,   mem_word(32'h0C),   1'b1};
        vecs[11] = '{1'b1, 1'b0, 32'h00, 1'b1, OPC_BEQ,   mem_word(32'h0C),   1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'h14, 1'b1, OPC_RTYPE, mem_word(32'h10),   1'b0};

        rst_n = 1'b0;  rst2_n = 1'b0;
        stall = 1'b0;  branch_taken = 1'b0;  branch_target = '0;
        imem_valid = 1'b0;  imem_rdata = '0;
        valid2 = 1'b0;  rdata2 = '0;

        repeat (2) @(posedge clk);
        #1;
        check32("rst_req",   32'(imem_req), 32'h0);
        check32("rst_addr",  imem_addr, 32'h0);
        check32("rst_valid", 32'(if_valid), 32'h0);
        check32("rst_instr", if_instr, 32'h0);
        check32("rst_opc",   32'(if_opc), 32'h0);
        check32("rst_funct", 32'(if_funct), 32'h0);
        check32("rst_pc4",   if_pc_plus4, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            stall = vecs[i].stall;
            tick();
            check32($sformatf("vec%0d_req", i),   32'(imem_req), 32'(vecs[i].exp_req));
            check32($sformatf("vec%0d_addr", i),  imem_addr, vecs[i].exp_addr);
            check32($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
            check32($sformatf("vec%0d_full", i),  32'(dut.r_state == ST_FULL), 32'(vecs[i].exp_full));
            if (vecs[i].exp_valid) begin
                check32($sformatf("vec%0d_opc", i),   32'(if_opc), 32'(vecs[i].exp_opc));
                check32($sformatf("vec%0d_instr", i), if_instr, vecs[i].exp_instr);
            end
        end
        stall = 1'b0;
        repeat (4) tick();

        // Redirect while a request is being issued
        n = 0;
        while (!imem_req && n < 10) begin
            tick();
            n++;
        end
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_taken  = 1'b0;
        check32("br_issue_valid", 32'(if_valid), 32'h0);
        check32("br_issue_req",   32'(imem_req), 32'h0);
        wait_req("br_issue_addr", 32'h40);
        check32("br_issue_valid2", 32'(if_valid), 32'h0);
        tick();
        tick();
        check32("br_issue_instr", if_instr, mem_word(32'h40));
        check32("br_issue_pc4",   if_pc_plus4, 32'h44);

        // Redirect in the same cycle as a returning word, unaligned target
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h83;
        tick();
        branch_taken  = 1'b0;
        check32("br_rsp_req",   32'(imem_req), 32'h1);
        check32("br_rsp_addr",  imem_addr, 32'h80);
        check32("br_rsp_valid", 32'(if_valid), 32'h0);
        tick();
        tick();
        check32("br_rsp_instr", if_instr, mem_word(32'h80));
        check32("br_rsp_pc4",   if_pc_plus4, 32'h84);

        // Redirect while waiting on a slow read
        mem_lat = 3;
        n = 0;
        tick();
        while (!imem_req && n < 10) begin
            tick();
            n++;
        end
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        tick();
        branch_taken  = 1'b0;
        check32("br_wait_req",   32'(imem_req), 32'h0);
        check32("br_wait_valid", 32'(if_valid), 32'h0);
        wait_req("br_wait_addr", 32'h100);
        mem_lat = 1;
        repeat (6) tick();

        // Address wrap at the top of memory, then reset during a read
        rst2_n = 1'b1;
        tick();
        check32("wrap_req",  32'(req2), 32'h1);
        check32("wrap_addr", addr2, 32'hFFFF_FFFC);
        tick();
        valid2 = 1'b1;
        rdata2 = mem_word(32'hFFFF_FFFC);
        tick();
        valid2 = 1'b0;
        rdata2 = '0;
        check32("wrap_valid", 32'(if_valid2), 32'h1);
        check32("wrap_instr", if_instr2, mem_word(32'hFFFF_FFFC));
        check32("wrap_opc",   32'(if_opc2), 32'(OPC_BEQ));
        check32("wrap_pc4",   if_pc_plus4_2, 32'h0);
        check32("wrap_next",  addr2, 32'h0);
        tick();
        rst2_n = 1'b0;
        #1;
        check32("midrst_req",   32'(req2), 32'h0);
        check32("midrst_addr",  addr2, 32'h0);
        check32("midrst_valid", 32'(if_valid2), 32'h0);
        check32("midrst_instr", if_instr2, 32'h0);
        check32("midrst_opc",   32'(if_opc2), 32'h0);
        check32("midrst_funct", 32'(if_funct2), 32'h0);
        check32("midrst_pc4",   if_pc_plus4_2, 32'h0);
        tick();
        rst2_n = 1'b1;
        valid2 = 1'b1;
        rdata2 = 32'hFFFF_FFFF;
        tick();
        valid2 = 1'b0;
        rdata2 = '0;
        check32("stale_valid", 32'(if_valid2), 32'h0);
        check32("stale_req",   32'(req2), 32'h1);
        check32("stale_addr",  addr2, 32'hFFFF_FFFC);
        tick();
        check32("stale_valid2", 32'(if_valid2), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
